// File: rtl/harz_pkg.sv
// harz_pkg: Harz80 host-bus request encodings and bus-arbiter state/constants
package harz_pkg;
  typedef enum logic [2:0] {
    HARZ80_NONE        = 3'd0,
    HARZ80_MEM_READ    = 3'd1,
    HARZ80_MEM_WRITE_1 = 3'd2,
    HARZ80_IO_READ     = 3'd3,
    HARZ80_IO_WRITE    = 3'd4
  } harz_req_t;
  typedef enum logic [2:0] {
    ST_ARB,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GUARD
  } arb_state_t;
  localparam int ARB_TO_W        = 8;
  localparam int ARB_DEF_BUSY_TO = 15;
  function automatic int arb_wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/harzbus_if.sv
// harzbus_if: Harz80 host bus between a bus master and the slot MMU
interface harzbus_if;
  import harz_pkg::*;
  harz_req_t   request;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        busy;
  logic [7:0]  read_data;
  modport host (output request, output address, output write_data, input busy, input read_data);
  modport mmu  (input request, input address, input write_data, output busy, output read_data);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: picks the first valid request at or after a start index (index 0 when fixed)
module rr_picker #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_ptr,
  input  logic         i_fixed,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_base;
  assign w_base = i_fixed ? '0 : i_ptr;
  assign o_any  = |i_valid;
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_valid[(int'(w_base) + k) % N]) o_idx = W'((int'(w_base) + k) % N);
    o_onehot = o_any ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/harz_bus_arbiter.sv
// harz_bus_arbiter: shares the Harz80 host bus among NUM_REQ requesters,
// one access per grant, with locked bursts and a busy-rise timeout.
module harz_bus_arbiter
  import harz_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIXED_PRIO = 0,
  parameter int BUSY_TO    = ARB_DEF_BUSY_TO,
  localparam int W         = $clog2(NUM_REQ)
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  harz_req_t [NUM_REQ-1:0]  i_req_kind,
  input  logic [NUM_REQ-1:0][15:0] i_req_addr,
  input  logic [NUM_REQ-1:0][7:0]  i_req_wdata,
  input  logic [NUM_REQ-1:0]       i_req_lock,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic [7:0]               o_rdata,
  output logic [W-1:0]             o_grant_id,
  harzbus_if.host                  bus_Harz
);
  arb_state_t           r_state;
  logic [W-1:0]         r_ptr, r_gid;
  logic                 r_lock, r_err;
  logic [NUM_REQ-1:0]   r_gnt_oh, r_done;
  logic [7:0]           r_rdata;
  logic [ARB_TO_W-1:0]  r_to;
  logic [NUM_REQ-1:0]   w_pick_oh, w_win_oh;
  logic [W-1:0]         w_pick_idx, w_win, w_sel, w_nxt;
  logic                 w_any;
  rr_picker #(.N(NUM_REQ), .W(W)) u_pick (
    .i_valid  (i_req_valid),
    .i_ptr    (r_ptr),
    .i_fixed  (FIXED_PRIO != 0),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_any)
  );
  // A held lock bypasses the picker: only the owner may win.
  assign w_win    = r_lock ? r_gid : w_pick_idx;
  assign w_win_oh = r_lock ? NUM_REQ'(1) << r_gid : w_pick_oh;
  assign w_sel    = (r_state == ST_ARB) ? w_win : r_gid;
  assign w_nxt    = W'(arb_wrap_inc(int'(w_sel), NUM_REQ));
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_grant_id = r_gid;
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_state             <= ST_ARB;
      r_ptr               <= '0;
      r_gid               <= '0;
      r_lock              <= 1'b0;
      r_err               <= 1'b0;
      r_gnt_oh            <= '0;
      r_done              <= '0;
      r_rdata             <= '0;
      r_to                <= '0;
      bus_Harz.request    <= HARZ80_NONE;
      bus_Harz.address    <= '0;
      bus_Harz.write_data <= '0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        ST_ARB:
          if (r_lock && !i_req_valid[r_gid]) r_lock <= 1'b0;
          else if (w_any) begin
            r_gid    <= w_win;
            r_gnt_oh <= w_win_oh;
            if (i_req_kind[w_win] == HARZ80_NONE) begin
              r_done  <= w_win_oh;
              r_lock  <= i_req_lock[w_win];
              if (!i_req_lock[w_win]) r_ptr <= w_nxt;
              r_state <= ST_GUARD;
            end else begin
              bus_Harz.request    <= i_req_kind[w_win];
              bus_Harz.address    <= i_req_addr[w_win];
              bus_Harz.write_data <= i_req_wdata[w_win];
              r_state             <= ST_ISSUE;
            end
          end
        ST_ISSUE: begin
          bus_Harz.request <= HARZ80_NONE;
          r_to             <= '0;
          r_state          <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY:
          if (bus_Harz.busy) r_state <= ST_WAIT_DONE;
          else if (r_to == ARB_TO_W'(BUSY_TO - 1)) begin
            r_done  <= r_gnt_oh;
            r_err   <= 1'b1;
            r_lock  <= 1'b0;
            r_ptr   <= w_nxt;
            r_state <= ST_GUARD;
          end else r_to <= r_to + 1'b1;
        ST_WAIT_DONE:
          if (!bus_Harz.busy) begin
            r_rdata <= bus_Harz.read_data;
            r_done  <= r_gnt_oh;
            r_lock  <= i_req_lock[r_gid];
            if (!i_req_lock[r_gid]) r_ptr <= w_nxt;
            r_state <= ST_GUARD;
          end
        default: r_state <= ST_ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_harz_bus_arbiter.sv
// tb_harz_bus_arbiter: directed and randomized checks of the host-bus arbiter
module tb_harz_bus_arbiter;
  import harz_pkg::*;
  localparam int TO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] valid = '0, lock = '0, valid2;
  harz_req_t [2:0] kind;
  logic [2:0][15:0] addr;
  logic [2:0][7:0] wdata;
  logic [2:0] done, done2;
  logic err, err2;
  logic [7:0] rdata, rdata2;
  logic [1:0] gid, gid2;
  logic fp_en = 1'b0;
  assign valid2 = fp_en ? valid : 3'b000;
  harzbus_if hb();
  harzbus_if hb2();
  harz_bus_arbiter #(.NUM_REQ(3), .FIXED_PRIO(0), .BUSY_TO(TO)) dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_req_valid(valid), .i_req_kind(kind),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_lock(lock),
    .o_done(done), .o_err(err), .o_rdata(rdata), .o_grant_id(gid), .bus_Harz(hb));
  harz_bus_arbiter #(.NUM_REQ(3), .FIXED_PRIO(1), .BUSY_TO(TO)) dut_fp (
    .i_CLK(clk), .i_RST_n(rst_n), .i_req_valid(valid2), .i_req_kind(kind),
    .i_req_addr(addr), .i_req_wdata(wdata), .i_req_lock(lock),
    .o_done(done2), .o_err(err2), .o_rdata(rdata2), .o_grant_id(gid2), .bus_Harz(hb2));
  // MMU model: busy rises the cycle after a request and stays high mmu_lat cycles.
  int mmu_lat = 3, mmu_cnt = 0;
  bit mmu_never = 1'b0;
  logic [7:0] mmu_rd = '0;
  logic [31:0] log_q[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      hb.busy <= 1'b0;
      hb.read_data <= '0;
      mmu_cnt <= 0;
    end else if (hb.request != HARZ80_NONE) begin
      log_q.push_back({8'(hb.request), hb.address, hb.write_data});
      if (!mmu_never) begin
        hb.busy <= 1'b1;
        mmu_cnt <= mmu_lat - 1;
      end
    end else if (hb.busy) begin
      if (mmu_cnt == 0) begin
        hb.busy <= 1'b0;
        hb.read_data <= mmu_rd;
      end else mmu_cnt <= mmu_cnt - 1;
    end
  end
  always @(posedge clk) hb2.busy <= rst_n && (hb2.request != HARZ80_NONE);
  assign hb2.read_data = 8'h00;
  harz_req_t prev_req = HARZ80_NONE;
  int viol = 0;
  always @(negedge clk) begin
    if (hb.request != HARZ80_NONE && (hb.busy === 1'b1 || prev_req != HARZ80_NONE)) viol++;
    prev_req = hb.request;
  end
  int b_n = 0, b_bad = 0;
  always @(negedge clk)
    if (fp_en && done2 != 3'b000) begin
      b_n++;
      if (done2 != 3'b001 || gid2 != 2'd0 || err2 || rdata2 != 8'h00) b_bad++;
    end
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    lock = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask
  task automatic wait_done(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget && who < 0; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (done[k]) who = k;
    end
    chk("done_seen", 32'(|done), 32'd1);
  endtask
  function automatic int pick(input logic [2:0] p, input int ptr);
    for (int o = 0; o < 3; o++) if (p[(ptr + o) % 3]) return (ptr + o) % 3;
    return -1;
  endfunction
  function automatic logic [31:0] pop();
    return log_q.size() > 0 ? log_q.pop_front() : 32'hDEAD_BEEF;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t_iss, t_done, rc, nd, who, ptr, sz;
    logic [2:0] pend;
    logic [7:0] last_rd;
    for (int k = 0; k < 3; k++) begin
      kind[k] = HARZ80_NONE;
      addr[k] = '0;
      wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_req", 32'(hb.request), 32'(HARZ80_NONE));
    chk("rst_addr", 32'(hb.address), 0);
    chk("rst_wdata", 32'(hb.write_data), 0);
    rst_n = 1'b1;
    // single read from requester 1
    mmu_lat = 3;
    mmu_rd = 8'h5A;
    kind[1] = HARZ80_IO_READ;
    addr[1] = 16'h00A0;
    valid[1] = 1'b1;
    t_iss = -1; t_done = -1; rc = 0; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (hb.request != HARZ80_NONE) begin
        rc++;
        if (t_iss < 0) t_iss = i;
      end
      if (done != 3'b000) begin
        nd++;
        if (t_done < 0) begin
          t_done = i;
          chk("rd_done_vec", 32'(done), 32'h2);
          chk("rd_rdata", 32'(rdata), 32'h5A);
          chk("rd_err", 32'(err), 0);
          chk("rd_gid", 32'(gid), 1);
          valid[1] = 1'b0;
        end
      end
    end
    chk("rd_req_cycles", rc, 1);
    chk("rd_done_count", nd, 1);
    chk("rd_issue_lat", t_iss, 1);
    chk("rd_done_lat", t_done, 3 + 3);
    chk("rd_bus", pop(), {8'(HARZ80_IO_READ), 16'h00A0, 8'h00});
    // contention: round robin on dut, fixed priority on dut_fp
    do_reset();
    mmu_lat = 2;
    for (int k = 0; k < 3; k++) begin
      kind[k] = HARZ80_MEM_READ;
      addr[k] = 16'h1000 + 16'(k);
    end
    valid = 3'b111;
    fp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done(40, who);
      chk("rr_order", who, i % 3);
      chk("rr_gid", 32'(gid), i % 3);
    end
    fp_en = 1'b0;
    valid = '0;
    chk("fp_only0", b_bad, 0);
    chk("fp_served", 32'(b_n >= 3), 1);
    // locked burst by requester 2 while requester 0 waits
    do_reset();
    mmu_lat = 1;
    kind[2] = HARZ80_MEM_WRITE_1;
    addr[2] = 16'h8000;
    wdata[2] = 8'h11;
    lock[2] = 1'b1;
    valid[2] = 1'b1;
    @(negedge clk);
    kind[0] = HARZ80_MEM_READ;
    addr[0] = 16'h0123;
    wdata[0] = 8'h00;
    valid[0] = 1'b1;
    wait_done(40, who);
    chk("lk_first", who, 2);
    addr[2] = 16'h8001;
    wdata[2] = 8'h22;
    lock[2] = 1'b0;
    wait_done(40, who);
    chk("lk_second", who, 2);
    valid[2] = 1'b0;
    wait_done(40, who);
    chk("lk_then0", who, 0);
    valid[0] = 1'b0;
    chk("lk_bus0", pop(), {8'(HARZ80_MEM_WRITE_1), 16'h8000, 8'h11});
    chk("lk_bus1", pop(), {8'(HARZ80_MEM_WRITE_1), 16'h8001, 8'h22});
    chk("lk_bus2", pop(), {8'(HARZ80_MEM_READ), 16'h0123, 8'h00});
    // busy never rises
    do_reset();
    mmu_never = 1'b1;
    mmu_rd = 8'hEE;
    kind[0] = HARZ80_IO_WRITE;
    addr[0] = 16'h0042;
    wdata[0] = 8'h99;
    valid[0] = 1'b1;
    t_iss = -1; t_done = -1; rc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (hb.request != HARZ80_NONE) begin
        rc++;
        if (t_iss < 0) t_iss = i;
      end
      if (t_done > 0 && i == t_done + 1) begin
        chk("to_guard_done", 32'(done), 0);
        chk("to_guard_req", 32'(hb.request), 32'(HARZ80_NONE));
      end
      if (done != 3'b000 && t_done < 0) begin
        t_done = i;
        chk("to_done_vec", 32'(done), 32'h1);
        chk("to_err", 32'(err), 1);
        chk("to_rdata", 32'(rdata), 0);
        valid[0] = 1'b0;
      end
    end
    chk("to_lat", t_done - t_iss, TO + 1);
    chk("to_req_cycles", rc, 1);
    mmu_never = 1'b0;
    // reset while waiting for busy to fall, then a fresh request
    do_reset();
    mmu_lat = 8;
    mmu_rd = 8'h77;
    kind[1] = HARZ80_MEM_READ;
    addr[1] = 16'h2222;
    valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_busy", 32'(hb.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_req", 32'(hb.request), 32'(HARZ80_NONE));
    chk("mr_done", 32'(done), 0);
    rst_n = 1'b1;
    mmu_lat = 2;
    t_iss = -1; t_done = -1; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (hb.request != HARZ80_NONE && t_iss < 0) t_iss = i;
      if (done != 3'b000) begin
        nd++;
        if (t_done < 0) begin
          t_done = i;
          chk("mr_done_vec", 32'(done), 32'h2);
          chk("mr_rdata", 32'(rdata), 32'h77);
          valid[1] = 1'b0;
        end
      end
    end
    chk("mr_issue_lat", t_iss, 1);
    chk("mr_done_lat", t_done, 3 + 2);
    chk("mr_done_count", nd, 1);
    // NONE kind: done without a bus cycle
    sz = log_q.size();
    kind[2] = HARZ80_NONE;
    valid[2] = 1'b1;
    rc = 0;
    @(negedge clk);
    chk("none_done", 32'(done), 32'h4);
    chk("none_err", 32'(err), 0);
    chk("none_rdata", 32'(rdata), 32'h77);
    if (hb.request != HARZ80_NONE) rc++;
    valid[2] = 1'b0;
    @(negedge clk);
    chk("none_pulse", 32'(done), 0);
    repeat (3) begin
      if (hb.request != HARZ80_NONE) rc++;
      @(negedge clk);
    end
    chk("none_req", rc, 0);
    chk("none_log", log_q.size(), sz);
    // randomized rounds against the round-robin rule
    do_reset();
    ptr = 0;
    last_rd = '0;
    for (int r = 0; r < 30; r++) begin
      pend = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) begin
        kind[k] = harz_req_t'($urandom_range(0, 4));
        addr[k] = 16'($urandom);
        wdata[k] = 8'($urandom);
      end
      mmu_lat = $urandom_range(1, 4);
      mmu_rd = 8'($urandom);
      valid = pend;
      while (pend != 3'b000) begin
        sz = log_q.size();
        wait_done(60, who);
        chk("rnd_who", who, pick(pend, ptr));
        if (who < 0) begin
          valid = '0;
          pend = '0;
        end else begin
          chk("rnd_vec", 32'(done), 1 << who);
          chk("rnd_err", 32'(err), 0);
          if (kind[who] == HARZ80_NONE) begin
            chk("rnd_none_rd", 32'(rdata), 32'(last_rd));
            chk("rnd_none_bus", log_q.size(), sz);
          end else begin
            chk("rnd_bus", pop(), {8'(kind[who]), addr[who], wdata[who]});
            chk("rnd_rdata", 32'(rdata), 32'(mmu_rd));
            last_rd = mmu_rd;
          end
          ptr = (who + 1) % 3;
          pend[who] = 1'b0;
          valid[who] = 1'b0;
          mmu_rd = 8'($urandom);
          mmu_lat = $urandom_range(1, 4);
        end
      end
    end
    chk("no_overlap", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
